idli_sqi_mem: RTL and testbench
===============================

Name: idli_sqi_mem

Overview:
- Synthesizable SQI (quad-SPI) SRAM responder: the memory end of the nibble-serial SQI link the core drives.
- Used as on-chip or FPGA program/data store, and as the SQI target in system benches.
- Accepts READ/WRITE transactions framed by active-low chip select. Transfers one nibble per clock, high nibble of each byte first.
- Holds a byte-addressed array with sequential-mode address auto-increment.

Parameters:
- DEPTH_LOG2, 8, log2 of array size in bytes (default 256 B). Legal range 1..16. Address is taken modulo 2^DEPTH_LOG2.

Ports:
- i_mem_clk   in   1  clock; SQI clock equals core clock, all sampling on rising edge
- i_mem_rst   in   1  synchronous active-high reset
- i_mem_cs    in   1  active-low chip select
- i_mem_sio   in   4  nibble from initiator
- o_mem_sio   out  4  nibble to initiator, registered
- o_mem_oe    out  1  high when o_mem_sio is driven (read data phase)

Behaviour:
- Reset: state IDLE, o_mem_sio=0, o_mem_oe=0, counters cleared. Array contents are not reset. Reset mid-transaction aborts it; no partial byte is written.
- Edge index n counts rising edges with i_mem_cs sampled low, starting at n=0. Any edge with cs=1 forces IDLE and o_mem_oe=0 after that edge, whatever the state.
- States: IDLE -> INSTR -> ADDR -> {DUMMY -> RD | WR}; unknown instruction -> IGNORE.
- INSTR (n=0,1): instruction byte, high nibble at n=0.
  - 0x03 = READ, 0x02 = WRITE.
  - Any other value -> IGNORE until cs high. Outputs stay 0 and oe stays 0 in IGNORE.
- ADDR (n=2..5): 16-bit address, MS nibble first. Bits above DEPTH_LOG2 are dropped.
- READ path:
  - DUMMY at n=6,7: input is ignored.
  - After edge 7: o_mem_oe=1 and o_mem_sio=mem[A][7:4].
  - After edge 8: o_mem_sio=mem[A][3:0]. After edge 9: mem[A+1][7:4], and so on.
  - Data is read from the array at the edge that loads the high nibble.
- WRITE path:
  - Data high nibble sampled at n=6, low nibble at n=7.
  - Byte committed to mem[A] at edge 7. Subsequent pairs go to A+1, A+2, ...
- Address increment wraps from 2^DEPTH_LOG2-1 to 0, for both read and write.
- cs deasserted mid-byte on a write: the half-received byte is discarded; earlier bytes remain written.
- cs deasserted during INSTR/ADDR/DUMMY: no array access occurs.
- Back-to-back transactions: one cs-high edge between them is sufficient. The new transaction starts at n=0 on the next low edge.
- A read issued after a write sees the written data; write commit precedes any later read edge.
- Array is single-port: one read or one write per cycle, never both.

Optional Feature:
- Macro IDLI_SQI_MEM_RDMR_EN.
- Defined:
  - Instruction 0x05 (read mode register) is accepted.
  - After edge 1, o_mem_oe=1 and o_mem_sio=0x4. After edge 2, o_mem_sio=0x0 (mode byte 0x40 = sequential).
  - The byte repeats every 2 edges until cs high. No address phase.
- Not defined: 0x05 is an unknown instruction -> IGNORE, o_mem_oe stays 0.

Test Plan:
- Reset, then idle cs=1 for 4 cycles -> o_mem_oe=0, o_mem_sio=0.
- WRITE 0x02, addr 0x0010, data nibbles A,5,3,C, then cs high; READ 0x03 addr 0x0010 -> after edges 7..10 o_mem_sio = A,5,3,C, o_mem_oe=1 from edge 7 until cs high.
- DEPTH_LOG2=8: WRITE at 0x00FF bytes 0x11,0x22; READ addr 0x0000 -> 0x22; READ addr 0x01FF -> 0x11 (upper bits ignored, wrap).
- WRITE addr 0x0020 byte 0x77, then 0x9 high nibble only, cs high -> mem[0x20]=0x77, mem[0x21] unchanged.
- Instruction 0xFF followed by 8 nibbles -> oe never asserted, no array change; next valid READ works normally.
- Assert i_mem_rst at READ edge 9 -> oe=0 next cycle; with IDLI_SQI_MEM_RDMR_EN, 0x05 -> o_mem_sio 4,0,4,0 from edge 1.

Source files
------------

// File: rtl/idli_sqi_mem.sv
// ---------------------------------------------------------------------------
// idli_sqi_mem -- SQI (quad-SPI) SRAM responder
//
// Memory end of the nibble-serial SQI link. One nibble moves per rising clock
// edge while cs is low, high nibble of each byte first. Transactions:
//   0x03 READ  : instr(2) addr(4) dummy(2) then data nibbles out
//   0x02 WRITE : instr(2) addr(4) then data nibbles in
//   0x05 RDMR  : only when IDLI_SQI_MEM_RDMR_EN is defined; streams the
//                mode byte 0x40 (sequential) until cs goes high.
// Any other instruction is ignored until cs goes high. The address
// auto-increments after every data byte and wraps at 2^DEPTH_LOG2.
//
// Optional build macro: IDLI_SQI_MEM_RDMR_EN (read-mode-register command).
//
// Parameters:
//   DEPTH_LOG2 - log2 of the array size in bytes (1..16)
//
// Ports:
//   i_mem_clk  - clock, all sampling on the rising edge
//   i_mem_rst  - synchronous active-high reset
//   i_mem_cs   - active-low chip select
//   i_mem_sio  - nibble from the initiator
//   o_mem_sio  - nibble to the initiator (registered)
//   o_mem_oe   - high while o_mem_sio carries read data
// ---------------------------------------------------------------------------
module idli_sqi_mem #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic       i_mem_clk,
    input  logic       i_mem_rst,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_oe
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [7:0] INSTR_READ  = 8'h03;
    localparam logic [7:0] INSTR_WRITE = 8'h02;
`ifdef IDLI_SQI_MEM_RDMR_EN
    localparam logic [7:0] INSTR_RDMR  = 8'h05;
`endif

    // Mode byte 0x40 (sequential mode), sent as two nibbles.
    localparam logic [3:0] MODE_HI = 4'h4;
    localparam logic [3:0] MODE_LO = 4'h0;

    localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {
        ST_IDLE,    // waiting for the first low-cs edge (instruction high nibble)
        ST_INSTR,   // instruction low nibble
        ST_ADDR,    // four address nibbles
        ST_DUMMY,   // two dummy edges ahead of read data
        ST_RD,      // streaming read data
        ST_WR,      // collecting write data
        ST_IGNORE,  // unknown instruction, wait for cs high
        ST_RDMR     // streaming the mode byte
    } state_t;

    state_t                  state_reg;
    logic [1:0]              cnt_reg;       // address nibble counter
    logic [3:0]              instr_hi_reg;  // instruction high nibble
    logic                    is_read_reg;   // decoded READ vs WRITE
    logic                    phase_reg;     // which half-byte the next edge handles
    logic [DEPTH_LOG2-1:0]   addr_reg;      // byte pointer, shifted in then incremented
    logic [3:0]              wr_hi_reg;     // high nibble of the byte being written
    logic [3:0]              sio_reg;
    logic                    oe_reg;

    // Single-port array and its registered read data.
    logic [7:0]              mem [0:DEPTH-1];
    logic [7:0]              rd_data_reg;

    // Array port controls for the current edge.
    logic                    mem_we;
    logic                    mem_re;
    logic [DEPTH_LOG2-1:0]   mem_addr;
    logic [7:0]              wr_byte;

    assign o_mem_sio = sio_reg;
    assign o_mem_oe  = oe_reg;

    // -----------------------------------------------------------------------
    // Array access decode.
    // The read for a byte is issued one edge before its high nibble goes out,
    // so the nibble can be loaded straight from the read-data register into
    // the output flop. Within a read transaction nothing can write the array,
    // so this is indistinguishable from reading on the high-nibble edge.
    // Both the access enables are killed by reset and by cs high, so an
    // aborted transaction never touches the array.
    // -----------------------------------------------------------------------
    always_comb begin
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = addr_reg;
        wr_byte  = {wr_hi_reg, i_mem_sio};
        if (!i_mem_rst && !i_mem_cs) begin
            case (state_reg)
                ST_DUMMY: begin
                    // First dummy edge: fetch byte A.
                    if (!phase_reg) begin
                        mem_re = 1'b1;
                    end
                end
                ST_RD: begin
                    // Low-nibble edge: fetch the next sequential byte.
                    if (!phase_reg) begin
                        mem_re   = 1'b1;
                        mem_addr = addr_reg + ADDR_ONE;
                    end
                end
                ST_WR: begin
                    // Low-nibble edge completes the byte: commit it.
                    if (phase_reg) begin
                        mem_we = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Array: no reset on contents; one access per cycle.
    always_ff @(posedge i_mem_clk) begin
        if (mem_we) begin
            mem[mem_addr] <= wr_byte;
        end else if (mem_re) begin
            rd_data_reg <= mem[mem_addr];
        end
    end

    // -----------------------------------------------------------------------
    // Protocol FSM with registered outputs.
    // phase_reg meaning per state:
    //   ST_DUMMY : 0 = first dummy edge next, 1 = second
    //   ST_RD    : 0 = next edge sends low nibble, 1 = next sends high nibble
    //   ST_WR    : 0 = next edge carries high nibble, 1 = low nibble
    //   ST_RDMR  : 0 = next edge sends MODE_HI, 1 = MODE_LO
    // -----------------------------------------------------------------------
    always_ff @(posedge i_mem_clk) begin
        if (i_mem_rst) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 2'd0;
            instr_hi_reg <= 4'h0;
            is_read_reg  <= 1'b0;
            phase_reg    <= 1'b0;
            addr_reg     <= '0;
            wr_hi_reg    <= 4'h0;
            sio_reg      <= 4'h0;
            oe_reg       <= 1'b0;
        end else if (i_mem_cs) begin
            // Deselect ends any transaction; a partial write byte is dropped.
            state_reg <= ST_IDLE;
            cnt_reg   <= 2'd0;
            phase_reg <= 1'b0;
            sio_reg   <= 4'h0;
            oe_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    instr_hi_reg <= i_mem_sio;
                    state_reg    <= ST_INSTR;
                end

                ST_INSTR: begin
                    cnt_reg   <= 2'd0;
                    phase_reg <= 1'b0;
                    case ({instr_hi_reg, i_mem_sio})
                        INSTR_READ: begin
                            is_read_reg <= 1'b1;
                            state_reg   <= ST_ADDR;
                        end
                        INSTR_WRITE: begin
                            is_read_reg <= 1'b0;
                            state_reg   <= ST_ADDR;
                        end
`ifdef IDLI_SQI_MEM_RDMR_EN
                        INSTR_RDMR: begin
                            oe_reg    <= 1'b1;
                            sio_reg   <= MODE_HI;
                            phase_reg <= 1'b1;
                            state_reg <= ST_RDMR;
                        end
`endif
                        default: begin
                            state_reg <= ST_IGNORE;
                        end
                    endcase
                end

                ST_ADDR: begin
                    // Shifting into a DEPTH_LOG2-wide register keeps only the
                    // low address bits, which is exactly the modulo wrap.
                    addr_reg <= DEPTH_LOG2'({addr_reg, i_mem_sio});
                    cnt_reg  <= cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        phase_reg <= 1'b0;
                        state_reg <= is_read_reg ? ST_DUMMY : ST_WR;
                    end
                end

                ST_DUMMY: begin
                    if (!phase_reg) begin
                        phase_reg <= 1'b1;
                    end else begin
                        oe_reg    <= 1'b1;
                        sio_reg   <= rd_data_reg[7:4];
                        phase_reg <= 1'b0;
                        state_reg <= ST_RD;
                    end
                end

                ST_RD: begin
                    if (!phase_reg) begin
                        // rd_data_reg is refetched on this same edge; the
                        // low nibble of the current byte is taken first.
                        sio_reg   <= rd_data_reg[3:0];
                        addr_reg  <= addr_reg + ADDR_ONE;
                        phase_reg <= 1'b1;
                    end else begin
                        sio_reg   <= rd_data_reg[7:4];
                        phase_reg <= 1'b0;
                    end
                end

                ST_WR: begin
                    if (!phase_reg) begin
                        wr_hi_reg <= i_mem_sio;
                        phase_reg <= 1'b1;
                    end else begin
                        addr_reg  <= addr_reg + ADDR_ONE;
                        phase_reg <= 1'b0;
                    end
                end

                ST_IGNORE: begin
                    // Hold outputs at zero until deselected.
                end

                ST_RDMR: begin
                    if (phase_reg) begin
                        sio_reg   <= MODE_LO;
                        phase_reg <= 1'b0;
                    end else begin
                        sio_reg   <= MODE_HI;
                        phase_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idli_sqi_mem.sv
// ---------------------------------------------------------------------------
// tb_idli_sqi_mem -- self-checking bench for idli_sqi_mem
//
// Drives SQI transactions nibble by nibble and compares every output nibble
// against a plain byte-array model of the memory (modulo addressing).
// Directed cases first, then randomized read/write traffic, then a full
// read-back of the array.
// ---------------------------------------------------------------------------
module tb_idli_sqi_mem;

    localparam int DL2   = 8;
    localparam int DEPTH = 1 << DL2;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic [3:0] sio_in;
    logic [3:0] sio_out;
    logic       oe;

    logic [7:0] model [DEPTH];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    idli_sqi_mem #(
        .DEPTH_LOG2 (DL2)
    ) dut (
        .i_mem_clk (clk),
        .i_mem_rst (rst),
        .i_mem_cs  (cs),
        .i_mem_sio (sio_in),
        .o_mem_sio (sio_out),
        .o_mem_oe  (oe)
    );

    // Drive one edge's inputs, then sample just after the rising edge.
    task automatic step(input logic c, input logic [3:0] n);
        cs     = c;
        sio_in = n;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    function automatic int midx(input logic [15:0] a, input int off);
        return (int'(a) + off) % DEPTH;
    endfunction

    task automatic send_hdr(input logic [7:0] instr, input logic [15:0] a);
        step(1'b0, instr[7:4]);
        step(1'b0, instr[3:0]);
        for (int k = 3; k >= 0; k--) begin
            step(1'b0, a[k*4 +: 4]);
            chk("hdr_quiet", {3'b000, oe, sio_out}, 8'h00);
        end
    endtask

    task automatic wr_txn(input logic [15:0] a, input bq_t d, input bit part, input logic [3:0] pn);
        send_hdr(8'h02, a);
        for (int i = 0; i < d.size(); i++) begin
            step(1'b0, d[i][7:4]);
            step(1'b0, d[i][3:0]);
            model[midx(a, i)] = d[i];
        end
        if (part) begin
            step(1'b0, pn);
        end
        chk("wr_oe", {7'd0, oe}, 8'h00);
        step(1'b1, 4'($urandom));
        chk("wr_end_oe", {7'd0, oe}, 8'h00);
        $display("txn write addr=%04h len=%0d partial=%0d", a, d.size(), part);
    endtask

    task automatic rd_txn(input logic [15:0] a, input int n);
        int idx;
        send_hdr(8'h03, a);
        step(1'b0, 4'($urandom));
        chk("dummy_oe", {7'd0, oe}, 8'h00);
        step(1'b0, 4'($urandom));
        for (int i = 0; i < n; i++) begin
            idx = midx(a, i);
            if (i > 0) begin
                step(1'b0, 4'($urandom));
            end
            chk("rd_hi", {3'b000, oe, sio_out}, {3'b000, 1'b1, model[idx][7:4]});
            step(1'b0, 4'($urandom));
            chk("rd_lo", {3'b000, oe, sio_out}, {3'b000, 1'b1, model[idx][3:0]});
        end
        step(1'b1, 4'h0);
        chk("rd_end", {3'b000, oe, sio_out}, 8'h00);
        $display("txn read  addr=%04h len=%0d", a, n);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t d;
        logic [15:0] a;
        int n;

        rst    = 1'b1;
        cs     = 1'b1;
        sio_in = 4'h0;
        step(1'b1, 4'h0);
        step(1'b1, 4'h0);
        chk("reset_out", {3'b000, oe, sio_out}, 8'h00);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 4'($urandom));
            chk("idle_out", {3'b000, oe, sio_out}, 8'h00);
        end
        $display("txn reset/idle");

        // Fill the whole array so every later read has a known value.
        d = {};
        for (int i = 0; i < DEPTH; i++) d.push_back(8'($urandom));
        wr_txn(16'h0000, d, 1'b0, 4'h0);

        // Basic write then read back: nibbles A,5,3,C.
        d = {8'hA5, 8'h3C};
        wr_txn(16'h0010, d, 1'b0, 4'h0);
        rd_txn(16'h0010, 2);

        // Wrap at the top of the array and upper address bits ignored.
        d = {8'h11, 8'h22};
        wr_txn(16'h00FF, d, 1'b0, 4'h0);
        rd_txn(16'h0000, 1);
        rd_txn(16'h01FF, 2);

        // Half byte discarded when cs rises mid-byte.
        d = {8'h77};
        wr_txn(16'h0020, d, 1'b1, 4'h9);
        rd_txn(16'h0020, 2);

        // Unknown instruction: outputs stay quiet.
        step(1'b0, 4'hF);
        step(1'b0, 4'hF);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 4'($urandom));
            chk("ignore_out", {3'b000, oe, sio_out}, 8'h00);
        end
        step(1'b1, 4'h0);
        $display("txn ignore instr=ff");
        rd_txn(16'h0040, 3);

        // Write aborted during the address phase: no array change.
        step(1'b0, 4'h0);
        step(1'b0, 4'h2);
        step(1'b0, 4'h0);
        step(1'b0, 4'h4);
        step(1'b1, 4'h0);
        $display("txn write aborted in address phase");

        // Reset at read edge 9.
        send_hdr(8'h03, 16'h0030);
        step(1'b0, 4'h0);
        step(1'b0, 4'h0);
        chk("rst_pre_hi", {3'b000, oe, sio_out}, {3'b000, 1'b1, model[8'h30][7:4]});
        step(1'b0, 4'h0);
        chk("rst_pre_lo", {3'b000, oe, sio_out}, {3'b000, 1'b1, model[8'h30][3:0]});
        rst = 1'b1;
        step(1'b0, 4'h0);
        chk("rst_mid_read", {3'b000, oe, sio_out}, 8'h00);
        rst = 1'b0;
        step(1'b1, 4'h0);
        $display("txn read reset at edge 9");
        rd_txn(16'h0030, 2);

        // Read mode register command.
        step(1'b0, 4'h0);
        step(1'b0, 4'h5);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step(1'b0, 4'($urandom));
`ifdef IDLI_SQI_MEM_RDMR_EN
            chk("rdmr", {3'b000, oe, sio_out}, (i % 2 == 0) ? 8'h14 : 8'h10);
`else
            chk("rdmr_off", {3'b000, oe, sio_out}, 8'h00);
`endif
        end
        step(1'b1, 4'h0);
        chk("rdmr_end", {3'b000, oe, sio_out}, 8'h00);
        $display("txn instr=05");

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            a = 16'($urandom);
            n = $urandom_range(1, 5);
            if ($urandom_range(0, 1) == 1) begin
                d = {};
                for (int i = 0; i < n; i++) d.push_back(8'($urandom));
                wr_txn(a, d, ($urandom_range(0, 3) == 0), 4'($urandom));
            end else begin
                rd_txn(a, n);
            end
        end

        // Full read-back of the array.
        rd_txn(16'($urandom), DEPTH);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
